signed_window_extrema: RTL and testbench

- Streaming stage that consumes signed samples over a valid/ready handshake and reports the maximum and minimum of each window of WIN_LEN samples, with the index of each.
- Sits directly downstream of the signed magnitude comparator. Each accepted sample is compared against the running max and the running min using two instances of that comparison function.
- Results feed threshold/alarm logic over a second valid/ready handshake.
- Windows are non-overlapping and back-to-back.

---
 rtl/signed_extrema_pkg.sv | 17 +
 rtl/signed_cmp_core.sv | 16 +
 rtl/signed_window_extrema.sv | 165 ++++++++++++++++
 tb/tb_signed_window_extrema.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_extrema_pkg.sv
// Shared types and constants for the signed window extrema stage.
package signed_extrema_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DATA_W_DEF = 4;

    // A window of 2 still needs a 1-bit position counter.
    function automatic int idx_w(input int win_len);
        return (win_len <= 2) ? 1 : $clog2(win_len);
    endfunction

endpackage

// File: rtl/signed_cmp_core.sv
// Full-width two's complement magnitude comparison of a against b.
module signed_cmp_core #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    assign gt = $signed(a) > $signed(b);
    assign lt = $signed(a) < $signed(b);
    assign eq = (a == b);

endmodule

// File: rtl/signed_window_extrema.sv
// Tracks signed max/min (with first-occurrence index) over non-overlapping
// windows of WIN_LEN samples and hands each result downstream.
//   state | meaning
//   IDLE  | out of reset, arming in_ready
//   ACCUM | accepting samples of the current window
//   HOLD  | result presented, waiting for out_ready
module signed_window_extrema
    import signed_extrema_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int WIN_LEN = 8,
    parameter int IDX_W   = idx_w(WIN_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_max_idx,
    output logic [IDX_W-1:0]  out_min_idx,
    output logic              out_flat
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WIN_LEN - 1);

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  run_max_q, run_min_q;
    logic [IDX_W-1:0]   max_idx_q, min_idx_q;
    logic [DATA_W-1:0]  out_max_q, out_min_q;
    logic [IDX_W-1:0]   out_max_idx_q, out_min_idx_q;
    logic               out_flat_q;

    logic [DATA_W-1:0]  run_max_d, run_min_d;
    logic [IDX_W-1:0]   max_idx_d, min_idx_d;
    logic               accept, first_pos, last_pos;
    logic               gt_max, lt_max, eq_max;
    logic               gt_min, lt_min, eq_min;
    logic               unused_cmp;

    signed_cmp_core #(.DATA_W(DATA_W)) u_cmp_max (
        .a  (in_data),
        .b  (run_max_q),
        .gt (gt_max),
        .lt (lt_max),
        .eq (eq_max)
    );

    signed_cmp_core #(.DATA_W(DATA_W)) u_cmp_min (
        .a  (in_data),
        .b  (run_min_q),
        .gt (gt_min),
        .lt (lt_min),
        .eq (eq_min)
    );

    assign unused_cmp = &{1'b0, lt_max, eq_max, gt_min, eq_min};

    assign accept    = in_valid && in_ready_q;
    assign first_pos = (cnt_q == '0);
    assign last_pos  = (cnt_q == LAST_POS);

    // Strict compares so ties keep the earliest index.
    always_comb begin
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        if (first_pos) begin
            run_max_d = in_data;
            run_min_d = in_data;
            max_idx_d = '0;
            min_idx_d = '0;
        end else begin
            if (gt_max) begin
                run_max_d = in_data;
                max_idx_d = cnt_q;
            end
            if (lt_min) begin
                run_min_d = in_data;
                min_idx_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            cnt_q         <= '0;
            run_max_q     <= '0;
            run_min_q     <= '0;
            max_idx_q     <= '0;
            min_idx_q     <= '0;
            out_max_q     <= '0;
            out_min_q     <= '0;
            out_max_idx_q <= '0;
            out_min_idx_q <= '0;
            out_flat_q    <= 1'b0;
        end else if (clear) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= ACCUM;
                    in_ready_q <= 1'b1;
                end
                ACCUM: begin
                    if (accept) begin
                        run_max_q <= run_max_d;
                        run_min_q <= run_min_d;
                        max_idx_q <= max_idx_d;
                        min_idx_q <= min_idx_d;
                        if (last_pos) begin
                            cnt_q         <= '0;
                            out_max_q     <= run_max_d;
                            out_min_q     <= run_min_d;
                            out_max_idx_q <= max_idx_d;
                            out_min_idx_q <= min_idx_d;
                            out_flat_q    <= (run_max_d == run_min_d);
                            out_valid_q   <= 1'b1;
                            in_ready_q    <= 1'b0;
                            state_q       <= HOLD;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ACCUM;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_max     = out_max_q;
    assign out_min     = out_min_q;
    assign out_max_idx = out_max_idx_q;
    assign out_min_idx = out_min_idx_q;
    assign out_flat    = out_flat_q;

endmodule

// File: tb/tb_signed_window_extrema.sv
// Directed plus randomized bench for signed_window_extrema (DATA_W=4, WIN_LEN=8)
// against a per-window reference computed from whole-window arithmetic.
module tb_signed_window_extrema;

    localparam int DW = 4;
    localparam int WL = 8;
    localparam int IW = 3;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_max;
    logic [DW-1:0] out_min;
    logic [IW-1:0] out_max_idx;
    logic [IW-1:0] out_min_idx;
    logic          out_flat;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] win [WL];
    logic [DW-1:0] e_max, e_min;
    logic [IW-1:0] e_max_idx, e_min_idx;
    logic          e_flat;

    signed_window_extrema #(.DATA_W(DW), .WIN_LEN(WL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_min     (out_min),
        .out_max_idx (out_max_idx),
        .out_min_idx (out_min_idx),
        .out_flat    (out_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: max/min as integers over the whole window, index = first position holding it.
    task automatic model();
        int vmax, vmin, v;
        bit fmax, fmin;
        vmax = -1000;
        vmin = 1000;
        for (int i = 0; i < WL; i++) begin
            v = int'(win[i]);
            if (v > vmax) vmax = v;
            if (v < vmin) vmin = v;
        end
        fmax = 0;
        fmin = 0;
        e_max_idx = '0;
        e_min_idx = '0;
        for (int i = 0; i < WL; i++) begin
            v = int'(win[i]);
            if (!fmax && v == vmax) begin e_max_idx = IW'(i); fmax = 1; end
            if (!fmin && v == vmin) begin e_min_idx = IW'(i); fmin = 1; end
        end
        e_max  = DW'(vmax);
        e_min  = DW'(vmin);
        e_flat = (vmax == vmin);
    endtask

    // Presents win[0..n-1]; returns right after the edge that accepts the last one.
    task automatic feed(input int n, input bit bubbles);
        int guard;
        logic was_ready;
        for (int i = 0; i < n; i++) begin
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = DW'($urandom);
                    step();
                end
            end
            in_valid = 1'b1;
            in_data  = win[i];
            guard = 0;
            do begin
                was_ready = in_ready;
                step();
                guard++;
            end while (!was_ready && guard < 50);
            if (!was_ready) begin
                chk("feed_timeout_in_ready", {31'b0, in_ready}, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic check_result(input string tag);
        model();
        chk({tag, "_valid"},   {31'b0, out_valid}, 32'd1);
        chk({tag, "_ready0"},  {31'b0, in_ready},  32'd0);
        chk({tag, "_max"},     {28'b0, out_max},   {28'b0, e_max});
        chk({tag, "_min"},     {28'b0, out_min},   {28'b0, e_min});
        chk({tag, "_max_idx"}, {29'b0, out_max_idx}, {29'b0, e_max_idx});
        chk({tag, "_min_idx"}, {29'b0, out_min_idx}, {29'b0, e_min_idx});
        chk({tag, "_flat"},    {31'b0, out_flat},  {31'b0, e_flat});
    endtask

    // Holds out_ready low for `hold` cycles with samples offered, then drains.
    task automatic drain(input string tag, input int hold);
        repeat (hold) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            step();
            chk({tag, "_bp_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tag, "_bp_ready"}, {31'b0, in_ready},  32'd0);
            chk({tag, "_bp_max"},   {28'b0, out_max},   {28'b0, e_max});
            chk({tag, "_bp_min"},   {28'b0, out_min},   {28'b0, e_min});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_drain_ready"}, {31'b0, in_ready},  32'd1);
        chk({tag, "_retain_max"},  {28'b0, out_max},   {28'b0, e_max});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},   {31'b0, out_valid}, 32'd0);
        chk({tag, "_ready"},   {31'b0, in_ready},  32'd0);
        chk({tag, "_outs"},    {17'b0, out_max, out_min, out_max_idx, out_min_idx, out_flat}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        for (int i = 0; i < WL; i++) win[i] = '0;

        // Reset, handshakes during reset ignored
        step();
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        check_zero("reset");
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        step();
        chk("reset_ready_after_1", {31'b0, in_ready}, 32'd1);

        // Test 1: mixed-sign window
        win = '{4'sd3, -4'sd2, 4'sd7, 4'sd0, -4'sd8, 4'sd5, 4'sd7, 4'sd1};
        feed(WL, 1'b0);
        check_result("t1");
        chk("t1_max_const", {28'b0, out_max}, 32'd7);
        chk("t1_max_idx_const", {29'b0, out_max_idx}, 32'd2);
        chk("t1_min_const", {28'b0, out_min}, 32'h8);
        chk("t1_min_idx_const", {29'b0, out_min_idx}, 32'd4);
        drain("t1", 0);

        // Test 2: flat window of -1
        for (int i = 0; i < WL; i++) win[i] = -4'sd1;
        feed(WL, 1'b1);
        check_result("t2");
        chk("t2_flat_const", {31'b0, out_flat}, 32'd1);
        drain("t2", 0);

        // Test 4 + 3: sign boundary window, then 5 cycles of backpressure
        for (int i = 0; i < WL; i++) win[i] = (i % 2 == 0) ? -4'sd8 : 4'sd7;
        feed(WL, 1'b0);
        check_result("t4");
        chk("t4_max_idx_const", {29'b0, out_max_idx}, 32'd1);
        chk("t4_min_idx_const", {29'b0, out_min_idx}, 32'd0);
        drain("t3", 5);
        for (int i = 0; i < WL; i++) win[i] = DW'($urandom);
        feed(WL, 1'b0);
        check_result("t3_next");
        drain("t3_next", 0);

        // Test 5: clear after a partial window of -8s, then 0..7
        for (int i = 0; i < WL; i++) win[i] = -4'sd8;
        feed(4, 1'b1);
        in_valid = 1'b1; in_data = 4'd7; clear = 1'b1;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("t5_clear_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_clear_ready", {31'b0, in_ready},  32'd1);
        chk("t5_clear_keep",  {28'b0, out_max},   {28'b0, e_max});
        for (int i = 0; i < WL; i++) win[i] = DW'(i);
        feed(WL, 1'b1);
        check_result("t5");
        chk("t5_max_idx_const", {29'b0, out_max_idx}, 32'd7);
        chk("t5_min_const", {28'b0, out_min}, 32'd0);

        // clear while a result is pending discards it but keeps data outputs
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t5_hold_clear_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_hold_clear_ready", {31'b0, in_ready},  32'd1);
        chk("t5_hold_clear_keep",  {28'b0, out_max},   {28'b0, e_max});

        // Randomized windows with bubbles, ties and backpressure
        for (int w = 0; w < 24; w++) begin
            for (int i = 0; i < WL; i++)
                win[i] = (w % 3 == 0) ? DW'($urandom_range(0, 2)) : DW'($urandom);
            feed(WL, 1'b1);
            check_result("rand");
            drain("rand", int'($urandom_range(0, 3)));
        end

        // Test 6: reset while holding a result
        for (int i = 0; i < WL; i++) win[i] = DW'($urandom);
        feed(WL, 1'b0);
        check_result("t6_pre");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_zero("t6_reset");
        step();
        chk("t6_ready_after_1", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < WL; i++) win[i] = DW'($urandom);
        feed(WL, 1'b1);
        check_result("t6_post");
        drain("t6_post", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
